// File: rtl/cpu_core.sv
// cpu_core -- small multi-cycle register machine.
//
// Every instruction goes FETCH -> DECODE -> EXEC. Loads and stores add a MEM
// phase that holds a request until the data memory acknowledges it. WAITBTN
// adds BTN_WAIT/BTN_REL so that one button press is consumed exactly once.
// HALT is terminal until reset.
//
// Build option: define CPU_MUL_EN to enable opcode 8 (MUL). Without it,
// opcode 8 is undefined: it sets the sticky 'illegal' flag and acts as a NOP.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   imem_addr   instruction address (always equal to pc)
//   imem_data   instruction word, valid one cycle after imem_addr
//   dmem_req    data access request, held until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_addr   data address
//   dmem_wdata  store data
//   dmem_rdata  load data, valid with dmem_ack
//   dmem_ack    data access complete (only looked at in MEM)
//   btn         user buttons, already synchronised
//   out_data    value of the last OUT instruction
//   out_valid   one-cycle strobe following an OUT
//   halted      core has executed HALT
//   illegal     sticky, set by an undefined opcode
`timescale 1ns/1ps

module cpu_core #(
    parameter int DATA_W = 40,
    parameter int NREG   = 16,
    parameter int PC_W   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic [4:0]        btn,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              illegal
);

    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_WBTN = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        BTN_WAIT,
        BTN_REL,
        HALT
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NREG];

    // Instruction fields; register indices wrap modulo NREG.
    logic [3:0]        op;
    logic [15:0]       imm;
    logic [RIDX_W-1:0] dst_idx;
    logic [RIDX_W-1:0] src0_idx;
    logic [RIDX_W-1:0] src1_idx;
    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;

    assign op       = ir[31:28];
    assign imm      = ir[15:0];
    assign dst_idx  = RIDX_W'(32'(ir[27:24]) % NREG);
    assign src0_idx = RIDX_W'(32'(ir[23:20]) % NREG);
    assign src1_idx = RIDX_W'(32'(ir[19:16]) % NREG);
    // Operands are read combinationally from the register file, so they
    // always see the value from before this instruction's write-back.
    assign src0     = regs[src0_idx];
    assign src1     = regs[src1_idx];

    assign imem_addr = pc;

    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              op_undef;
    logic [PC_W-1:0]   pc_next;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        alu_res  = '0;
        alu_wr   = 1'b0;
        op_undef = 1'b0;
        pc_next  = pc + PC_W'(1);
        case (op)
            OP_NOP:  ;
            OP_LDI:  begin alu_res = DATA_W'(imm);        alu_wr = 1'b1; end
            OP_ADD:  begin alu_res = src0 + src1;         alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = src0 - src1;         alu_wr = 1'b1; end
            OP_AND:  begin alu_res = src0 & src1;         alu_wr = 1'b1; end
            OP_OR:   begin alu_res = src0 | src1;         alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = src0 ^ src1;         alu_wr = 1'b1; end
            OP_SHL:  begin alu_res = src0 << src1[5:0];   alu_wr = 1'b1; end
`ifdef CPU_MUL_EN
            OP_MUL:  begin alu_res = src0 * src1;         alu_wr = 1'b1; end
`else
            OP_MUL:  op_undef = 1'b1;
`endif
            OP_JMP:  pc_next = imm[PC_W-1:0];
            OP_BEQ:  if (src0 == src1) pc_next = imm[PC_W-1:0];
            OP_HALT: pc_next = pc;
            default: ;
        endcase
    end

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every branch sees the register values from the start of the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            // NOTE: the register file is cleared on reset, so it is built from
            // flops with a reset loop rather than a plain memory array.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: state <= DECODE;

                DECODE: begin
                    ir    <= imem_data;
                    state <= EXEC;
                end

                EXEC: begin
                    pc    <= pc_next;
                    state <= FETCH;
                    if (alu_wr)   regs[dst_idx] <= alu_res;
                    if (op_undef) illegal <= 1'b1;
                    case (op)
                        OP_LD, OP_ST: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= src1[ADDR_W-1:0];
                            dmem_wdata <= src0;
                            state      <= MEM;
                        end
                        OP_WBTN: state <= BTN_WAIT;
                        OP_OUT: begin
                            out_data  <= src0;
                            out_valid <= 1'b1;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: ;
                    endcase
                end

                // Address and data stay in their registers until the ack.
                MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we) regs[dst_idx] <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= FETCH;
                    end
                end

                BTN_WAIT: begin
                    if (btn != '0) begin
                        regs[dst_idx] <= DATA_W'(btn);
                        state         <= BTN_REL;
                    end
                end

                // Wait for release so a long press is not taken twice.
                BTN_REL: if (btn == '0) state <= FETCH;

                HALT: state <= HALT;

                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: directed programs with hand-computed results.
// ALU cases come from a vector table; memory, button, jump, branch, halt,
// illegal-opcode and reset cases are written out as sequences.
`timescale 1ns/1ps

module tb_cpu_core;

    localparam int DATA_W = 40;
    localparam int NREG   = 16;
    localparam int PC_W   = 8;
    localparam int ADDR_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_WBTN = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [4:0]        btn;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic              illegal;

    cpu_core #(
        .DATA_W(DATA_W),
        .NREG  (NREG),
        .PC_W  (PC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ack  (dmem_ack),
        .btn       (btn),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Instruction ROM: combinational, so data is stable throughout DECODE.
    logic [31:0] rom [256];
    assign imem_data = rom[imem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] dst,
                                        input logic [3:0] s0, input logic [3:0] s1,
                                        input logic [15:0] imm);
        return {op, dst, s0, s1, imm};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Leaves us on a negedge with rst just released; the next posedge ends FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int cycles, output logic ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_halt(input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            step(1);
            if (halted) ok = 1'b1;
        end
    endtask

    // ---------------- data memory model ----------------
    // Acks after ack_delay cycles of request; logs each access.
    logic [DATA_W-1:0] dmem [256];
    int                ack_delay = 0;
    int                ack_cnt   = 0;
    int                run_len   = 0;
    int                acc_n     = 0;
    int                post_ack_req = 0;
    logic              ack_prev  = 1'b0;
    logic              run_unst;
    logic [ADDR_W-1:0] run_addr;
    logic              run_we;
    logic [DATA_W-1:0] run_wdata;
    int                log_len   [8];
    logic [ADDR_W-1:0] log_addr  [8];
    logic              log_we    [8];
    logic [DATA_W-1:0] log_wdata [8];
    logic              log_unst  [8];

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ack_prev && dmem_req) post_ack_req++;
            ack_prev = 1'b0;
            if (dmem_req && !rst) begin
                if (run_len == 0) begin
                    run_addr  = dmem_addr;
                    run_we    = dmem_we;
                    run_wdata = dmem_wdata;
                    run_unst  = 1'b0;
                end else if (dmem_addr !== run_addr || dmem_we !== run_we ||
                             dmem_wdata !== run_wdata) begin
                    run_unst = 1'b1;
                end
                run_len++;
                if (ack_cnt >= ack_delay) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dmem_rdata = dmem[dmem_addr];
                    if (acc_n < 8) begin
                        log_len[acc_n]   = run_len;
                        log_addr[acc_n]  = run_addr;
                        log_we[acc_n]    = run_we;
                        log_wdata[acc_n] = run_wdata;
                        log_unst[acc_n]  = run_unst;
                    end
                    acc_n++;
                    ack_cnt  = 0;
                    run_len  = 0;
                    ack_prev = 1'b1;
                end else begin
                    dmem_ack = 1'b0;
                    ack_cnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                ack_cnt  = 0;
                run_len  = 0;
            end
        end
    end

    // ---------------- ALU vector table ----------------
    typedef struct {
        string             name;
        logic [3:0]        op;
        logic [15:0]       a;
        logic [15:0]       b;
        logic [DATA_W-1:0] exp;
    } alu_vec_t;

    localparam int NVEC = 11;
    alu_vec_t vecs [NVEC];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic ok;
        int   base_acc;
        int   base_post;
        logic [PC_W-1:0] addr_hold;
        int   spur;
        int   moved;
        int   pulses;
        int   reqs;

        rst = 1'b1;
        btn = '0;
        clear_rom();

        vecs[0]  = '{"add_5_7",     OP_ADD, 16'd5,      16'd7,      40'd12};
        vecs[1]  = '{"sub_0_1",     OP_SUB, 16'd0,      16'd1,      40'hFF_FFFF_FFFF};
        vecs[2]  = '{"sub_7_5",     OP_SUB, 16'd7,      16'd5,      40'd2};
        vecs[3]  = '{"add_carry",   OP_ADD, 16'hFFFF,   16'hFFFF,   40'h1_FFFE};
        vecs[4]  = '{"and",         OP_AND, 16'hF0F0,   16'hFF00,   40'hF000};
        vecs[5]  = '{"or",          OP_OR,  16'hF0F0,   16'h0F0F,   40'hFFFF};
        vecs[6]  = '{"xor",         OP_XOR, 16'hFFFF,   16'h1234,   40'hEDCB};
        vecs[7]  = '{"shl_1_39",    OP_SHL, 16'd1,      16'd39,     40'h80_0000_0000};
        vecs[8]  = '{"shl_trunc",   OP_SHL, 16'hFFFF,   16'd32,     40'hFF_0000_0000};
        vecs[9]  = '{"shl_1_40",    OP_SHL, 16'd1,      16'd40,     40'd0};
        vecs[10] = '{"shl_amt_6b",  OP_SHL, 16'd1,      16'h0041,   40'd2};

        // LDI r1,a; LDI r2,b; OP r3,r1,r2; OUT r3 -> strobe right after cycle 12.
        for (int i = 0; i < NVEC; i++) begin
            clear_rom();
            rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, vecs[i].a);
            rom[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, vecs[i].b);
            rom[2] = enc(vecs[i].op, 4'd3, 4'd1, 4'd2, 16'd0);
            rom[3] = enc(OP_OUT, 4'd0, 4'd3, 4'd0, 16'd0);
            rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
            do_reset();
            wait_out(40, cyc, ok);
            check({vecs[i].name, " out_seen"}, 64'(ok), 64'd1);
            check({vecs[i].name, " out_data"}, 64'(out_data), 64'(vecs[i].exp));
            check({vecs[i].name, " cycles"}, 64'(cyc), 64'd12);
            step(1);
            check({vecs[i].name, " pulse_width"}, 64'(out_valid), 64'd0);
        end

        // Source equal to destination reads the old value.
        clear_rom();
        rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'd5);
        rom[1] = enc(OP_ADD, 4'd1, 4'd1, 4'd1, 16'd0);
        rom[2] = enc(OP_ADD, 4'd1, 4'd1, 4'd1, 16'd0);
        rom[3] = enc(OP_OUT, 4'd0, 4'd1, 4'd0, 16'd0);
        rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        do_reset();
        wait_out(40, cyc, ok);
        check("src_eq_dst out_data", 64'(out_data), 64'd20);

        // Store with a 4-cycle ack delay, then load it back.
        clear_rom();
        rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h1234);
        rom[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'd3);
        rom[2] = enc(OP_ST,  4'd0, 4'd1, 4'd2, 16'd0);
        rom[3] = enc(OP_LD,  4'd5, 4'd0, 4'd2, 16'd0);
        rom[4] = enc(OP_OUT, 4'd0, 4'd5, 4'd0, 16'd0);
        rom[5] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        ack_delay = 4;
        base_acc  = acc_n;
        base_post = post_ack_req;
        do_reset();
        wait_out(200, cyc, ok);
        check("mem out_seen", 64'(ok), 64'd1);
        check("mem load_value", 64'(out_data), 64'h1234);
        check("mem access_count", 64'(acc_n - base_acc), 64'd2);
        if (acc_n - base_acc == 2) begin
            check("st req_cycles", 64'(log_len[base_acc]), 64'd5);
            check("st addr", 64'(log_addr[base_acc]), 64'd3);
            check("st we", 64'(log_we[base_acc]), 64'd1);
            check("st wdata", 64'(log_wdata[base_acc]), 64'h1234);
            check("st stable", 64'(log_unst[base_acc]), 64'd0);
            check("ld we", 64'(log_we[base_acc+1]), 64'd0);
            check("ld addr", 64'(log_addr[base_acc+1]), 64'd3);
        end
        check("req_dropped_after_ack", 64'(post_ack_req - base_post), 64'd0);
        ack_delay = 0;

        // WAITBTN r4: stall while btn==0, capture, stall while held.
        clear_rom();
        rom[0] = enc(OP_WBTN, 4'd4, 4'd0, 4'd0, 16'd0);
        rom[1] = enc(OP_OUT,  4'd0, 4'd4, 4'd0, 16'd0);
        rom[2] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        btn = '0;
        do_reset();
        step(4);
        addr_hold = imem_addr;
        spur  = 0;
        moved = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (out_valid) spur++;
            if (imem_addr !== addr_hold) moved++;
        end
        btn = 5'b00100;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (out_valid) spur++;
            if (imem_addr !== addr_hold) moved++;
        end
        check("btn no_early_out", 64'(spur), 64'd0);
        check("btn pc_stalled", 64'(moved), 64'd0);
        btn = '0;
        wait_out(20, cyc, ok);
        check("btn out_seen", 64'(ok), 64'd1);
        check("btn captured", 64'(out_data), 64'd4);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (out_valid) pulses++;
        end
        check("btn single_advance", 64'(pulses), 64'd0);
        check("btn halted", 64'(halted), 64'd1);

        // JMP 255, NOP at 255, pc wraps to 0.
        clear_rom();
        rom[0] = enc(OP_JMP, 4'd0, 4'd0, 4'd0, 16'h00FF);
        do_reset();
        check("jmp pc_at_reset", 64'(imem_addr), 64'd0);
        step(3);
        check("jmp target", 64'(imem_addr), 64'd255);
        step(3);
        check("pc_wrap", 64'(imem_addr), 64'd0);

        // BEQ taken (9==9) and not taken (9!=8).
        for (int t = 0; t < 2; t++) begin
            clear_rom();
            rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'd9);
            rom[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, (t == 0) ? 16'd9 : 16'd8);
            rom[2] = enc(OP_BEQ, 4'd0, 4'd1, 4'd2, 16'd5);
            rom[3] = enc(OP_OUT, 4'd0, 4'd1, 4'd0, 16'd0);
            rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
            rom[5] = enc(OP_LDI, 4'd3, 4'd0, 4'd0, 16'h77);
            rom[6] = enc(OP_OUT, 4'd0, 4'd3, 4'd0, 16'd0);
            rom[7] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
            do_reset();
            wait_out(40, cyc, ok);
            check((t == 0) ? "beq taken" : "beq not_taken", 64'(out_data),
                  (t == 0) ? 64'h77 : 64'd9);
        end

        // Opcode 8: MUL when enabled, otherwise illegal and a NOP.
        clear_rom();
        rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'd6);
        rom[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'd7);
        rom[2] = enc(OP_MUL, 4'd3, 4'd1, 4'd2, 16'd0);
        rom[3] = enc(OP_OUT, 4'd0, 4'd3, 4'd0, 16'd0);
        rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        do_reset();
        check("illegal clear_at_start", 64'(illegal), 64'd0);
        wait_out(40, cyc, ok);
`ifdef CPU_MUL_EN
        check("mul result", 64'(out_data), 64'd42);
        check("mul not_illegal", 64'(illegal), 64'd0);
`else
        check("op8 nop_result", 64'(out_data), 64'd0);
        check("op8 illegal", 64'(illegal), 64'd1);
        step(6);
        check("op8 illegal_sticky", 64'(illegal), 64'd1);
`endif

        // HALT: terminal, pc frozen, no bus activity; illegal cleared by reset.
        clear_rom();
        rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'd1);
        rom[1] = enc(OP_OUT, 4'd0, 4'd1, 4'd0, 16'd0);
        rom[2] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        rom[3] = enc(OP_OUT, 4'd0, 4'd1, 4'd0, 16'd0);
        do_reset();
        check("illegal cleared_by_reset", 64'(illegal), 64'd0);
        wait_halt(40, ok);
        check("halt reached", 64'(ok), 64'd1);
        addr_hold = imem_addr;
        pulses = 0;
        moved  = 0;
        reqs   = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (out_valid) pulses++;
            if (dmem_req) reqs++;
            if (imem_addr !== addr_hold) moved++;
        end
        check("halt pc_frozen", 64'(moved), 64'd0);
        check("halt no_out", 64'(pulses), 64'd0);
        check("halt no_mem", 64'(reqs), 64'd0);
        check("halt still_halted", 64'(halted), 64'd1);

        // Reset values, taken from a halted core with out_data=1.
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("rst halted", 64'(halted), 64'd0);
        check("rst illegal", 64'(illegal), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst dmem_req", 64'(dmem_req), 64'd0);
        check("rst dmem_we", 64'(dmem_we), 64'd0);
        check("rst pc", 64'(imem_addr), 64'd0);

        // Reset in the middle of a load that is never acknowledged.
        clear_rom();
        rom[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'hAB);
        rom[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'd1);
        rom[2] = enc(OP_LD,  4'd6, 4'd0, 4'd2, 16'd0);
        ack_delay = 1000;
        do_reset();
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            step(1);
            if (dmem_req) ok = 1'b1;
        end
        check("midmem req_seen", 64'(ok), 64'd1);
        step(2);
        rst = 1'b1;
        step(1);
        check("midmem req_dropped", 64'(dmem_req), 64'd0);
        check("midmem pc_zero", 64'(imem_addr), 64'd0);
        ack_delay = 0;
        clear_rom();
        rom[0] = enc(OP_OUT, 4'd0, 4'd1, 4'd0, 16'd0);
        rom[1] = enc(OP_OUT, 4'd0, 4'd2, 4'd0, 16'd0);
        rom[2] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        do_reset();
        wait_out(20, cyc, ok);
        check("midmem r1_cleared_seen", 64'(ok), 64'd1);
        check("midmem r1_cleared", 64'(out_data), 64'd0);
        wait_out(20, cyc, ok);
        check("midmem r2_cleared_seen", 64'(ok), 64'd1);
        check("midmem r2_cleared", 64'(out_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
